// File: rtl/clk_reset_sequencer.sv
// -----------------------------------------------------------------------------
// clk_reset_sequencer
//   Brings up the fabric behind the 100 MHz clocking wizard. The wizard lock
//   flag is synchronized, must stay high for a settle interval, and then the
//   downstream reset domains are released one after another, lowest bit first.
//   Lock loss (RELEASE/RUN) or a soft-reset request re-asserts every domain
//   reset and restarts the sequence.
//
// Ports
//   clk_100mhz      in   1           wizard output clock
//   rst_n           in   1           asynchronous active-low reset
//   locked          in   1           wizard lock flag (asynchronous)
//   soft_reset      in   1           one-cycle request for a full re-sequence
//   rst_stage_n     out  NUM_STAGES  per-domain active-low resets, bit 0 first
//   ready           out  1           high only in RUN
//   seq_state       out  3           encoded FSM state (LED debug)
//   lock_loss_count out  8           saturating count of lock-loss events
// -----------------------------------------------------------------------------
module clk_reset_sequencer #(
    parameter int NUM_STAGES         = 3,
    parameter int LOCK_SETTLE_CYCLES = 1000,
    parameter int STAGE_GAP_CYCLES   = 16,
    parameter int SYNC_STAGES        = 2
) (
    input  logic                  clk_100mhz,
    input  logic                  rst_n,
    input  logic                  locked,
    input  logic                  soft_reset,
    output logic [NUM_STAGES-1:0] rst_stage_n,
    output logic                  ready,
    output logic [2:0]            seq_state,
    output logic [7:0]            lock_loss_count
);

    // RELEASE runs one cycle past the last stage's release slot before RUN.
    localparam int REL_SPAN  = (NUM_STAGES - 1) * STAGE_GAP_CYCLES + 1;
    localparam int TIMER_MAX = (LOCK_SETTLE_CYCLES > REL_SPAN) ? LOCK_SETTLE_CYCLES : REL_SPAN;
    localparam int TW        = $clog2(TIMER_MAX + 1);

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_SETTLE    = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    state_t                 r_state;
    logic [TW-1:0]          r_timer;
    logic [NUM_STAGES-1:0]  r_stage_n;
    logic                   r_ready;
    logic [7:0]             r_count;

    logic                   w_locked_s;
    state_t                 w_next_state;
    logic [TW-1:0]          w_next_timer;
    logic [NUM_STAGES-1:0]  w_next_stage_n;
    logic                   w_next_ready;
    logic [7:0]             w_next_count;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : (v + 8'd1);
    endfunction

    assign w_locked_s = r_sync[SYNC_STAGES-1];

    // Synchronizer chain bringing the wizard lock flag into clk_100mhz.
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {SYNC_STAGES{1'b0}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], locked};
        end
    end

    // Next-state, timer, stage-release and counter logic.
    always_comb begin
        w_next_state   = r_state;
        w_next_timer   = r_timer;
        w_next_stage_n = r_stage_n;
        w_next_count   = r_count;
        case (r_state)
            ST_RESET: begin
                w_next_state   = ST_WAIT_LOCK;
                w_next_timer   = {TW{1'b0}};
                w_next_stage_n = {NUM_STAGES{1'b0}};
            end
            ST_WAIT_LOCK: begin
                w_next_timer   = {TW{1'b0}};
                w_next_stage_n = {NUM_STAGES{1'b0}};
                if (w_locked_s) begin
                    w_next_state = ST_SETTLE;
                end else begin
                    w_next_state = ST_WAIT_LOCK;
                end
            end
            ST_SETTLE: begin
                w_next_stage_n = {NUM_STAGES{1'b0}};
                // Losing lock before any release is not counted as a lock loss.
                if (!w_locked_s) begin
                    w_next_state = ST_WAIT_LOCK;
                    w_next_timer = {TW{1'b0}};
                end else if (soft_reset) begin
                    w_next_state = ST_SETTLE;
                    w_next_timer = {TW{1'b0}};
                end else if (r_timer == TW'(LOCK_SETTLE_CYCLES - 1)) begin
                    w_next_state = ST_RELEASE;
                    w_next_timer = {TW{1'b0}};
                end else begin
                    w_next_timer = r_timer + {{(TW-1){1'b0}}, 1'b1};
                end
            end
            ST_RELEASE, ST_RUN: begin
                if (!w_locked_s) begin
                    w_next_state   = ST_WAIT_LOCK;
                    w_next_timer   = {TW{1'b0}};
                    w_next_stage_n = {NUM_STAGES{1'b0}};
                    w_next_count   = sat_inc8(r_count);
                end else if (soft_reset) begin
                    w_next_state   = ST_SETTLE;
                    w_next_timer   = {TW{1'b0}};
                    w_next_stage_n = {NUM_STAGES{1'b0}};
                end else if (r_state == ST_RUN) begin
                    w_next_stage_n = {NUM_STAGES{1'b1}};
                end else if (r_stage_n[NUM_STAGES-1]) begin
                    // Last stage went out on the previous edge.
                    w_next_state = ST_RUN;
                    w_next_timer = {TW{1'b0}};
                end else begin
                    w_next_timer = r_timer + {{(TW-1){1'b0}}, 1'b1};
                    // Release slots are strictly increasing in k, so bits only
                    // ever turn on in ascending order.
                    for (int k = 0; k < NUM_STAGES; k++) begin
                        if (r_timer == TW'(k * STAGE_GAP_CYCLES)) begin
                            w_next_stage_n[k] = 1'b1;
                        end else begin
                            w_next_stage_n[k] = r_stage_n[k];
                        end
                    end
                end
            end
            default: begin
                // Unreachable encodings recover by waiting for lock again.
                w_next_state   = ST_WAIT_LOCK;
                w_next_timer   = {TW{1'b0}};
                w_next_stage_n = {NUM_STAGES{1'b0}};
            end
        endcase
        w_next_ready = (w_next_state == ST_RUN);
    end

    // State, timer and registered outputs.
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_RESET;
            r_timer   <= {TW{1'b0}};
            r_stage_n <= {NUM_STAGES{1'b0}};
            r_ready   <= 1'b0;
            r_count   <= 8'd0;
        end else begin
            r_state   <= w_next_state;
            r_timer   <= w_next_timer;
            r_stage_n <= w_next_stage_n;
            r_ready   <= w_next_ready;
            r_count   <= w_next_count;
        end
    end

    assign rst_stage_n     = r_stage_n;
    assign ready           = r_ready;
    assign seq_state       = r_state;
    assign lock_loss_count = r_count;

endmodule

// File: tb/tb_clk_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_clk_reset_sequencer
//   Directed bench for clk_reset_sequencer with NUM_STAGES=3,
//   LOCK_SETTLE_CYCLES=8, STAGE_GAP_CYCLES=4, SYNC_STAGES=2. Expected output
//   tuples are pushed to a scoreboard queue and popped when sampled.
// -----------------------------------------------------------------------------
module tb_clk_reset_sequencer;

    localparam int N = 3;
    localparam int L = 8;
    localparam int G = 4;
    localparam int S = 2;

    logic         clk_100mhz = 1'b0;
    logic         rst_n;
    logic         locked;
    logic         soft_reset;
    logic [N-1:0] rst_stage_n;
    logic         ready;
    logic [2:0]   seq_state;
    logic [7:0]   lock_loss_count;

    typedef struct {
        string      tag;
        logic [2:0] stg;
        logic       rdy;
        logic [2:0] sq;
        logic [7:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   exp_cnt     = 0;

    clk_reset_sequencer #(
        .NUM_STAGES        (N),
        .LOCK_SETTLE_CYCLES(L),
        .STAGE_GAP_CYCLES  (G),
        .SYNC_STAGES       (S)
    ) dut (
        .clk_100mhz     (clk_100mhz),
        .rst_n          (rst_n),
        .locked         (locked),
        .soft_reset     (soft_reset),
        .rst_stage_n    (rst_stage_n),
        .ready          (ready),
        .seq_state      (seq_state),
        .lock_loss_count(lock_loss_count)
    );

    // 100 MHz clock.
    always #5 clk_100mhz = ~clk_100mhz;

    // Hard time limit so the run always terminates.
    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk_100mhz);
        #1;
    endtask

    task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [2:0] stg, input logic rdy,
                            input logic [2:0] sq, input logic [7:0] cnt);
        exp_t e;
        e.tag = tag;
        e.stg = stg;
        e.rdy = rdy;
        e.sq  = sq;
        e.cnt = cnt;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL scoreboard observed=empty expected=entry");
        end else begin
            e = sb.pop_front();
            cmp({e.tag, ".rst_stage_n"}, {5'd0, rst_stage_n}, {5'd0, e.stg});
            cmp({e.tag, ".ready"}, {7'd0, ready}, {7'd0, e.rdy});
            cmp({e.tag, ".seq_state"}, {5'd0, seq_state}, {5'd0, e.sq});
            cmp({e.tag, ".lock_loss_count"}, lock_loss_count, e.cnt);
        end
    endtask

    task automatic expect_now(input string tag, input logic [2:0] stg, input logic rdy,
                              input logic [2:0] sq, input logic [7:0] cnt);
        push_exp(tag, stg, rdy, sq, cnt);
        pop_check();
    endtask

    // Expected outputs at cycle c+off of a clean bring-up (c = lock seen in WAIT_LOCK).
    task automatic seq_check(input string tag, input logic [7:0] cnt, input int off);
        logic [2:0] stg;
        logic [2:0] sq;
        logic       rdy;
        for (int k = 0; k < N; k++) begin
            stg[k] = (off >= L + 2 + k * G);
        end
        if (off <= L) begin
            sq = 3'd2;
        end else if (off <= L + 2 + (N - 1) * G) begin
            sq = 3'd3;
        end else begin
            sq = 3'd4;
        end
        rdy = (off >= L + 3 + (N - 1) * G);
        expect_now($sformatf("%s@c+%0d", tag, off), stg, rdy, sq, cnt);
    endtask

    task automatic run_sequence(input string tag, input logic [7:0] cnt, input int first_off);
        for (int off = first_off; off <= L + 3 + (N - 1) * G; off++) begin
            step();
            seq_check(tag, cnt, off);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        locked     = 1'b1;
        soft_reset = 1'b0;

        // Reset held with lock present: everything stays at zero.
        repeat (3) step();
        expect_now("reset_hold", 3'b000, 1'b0, 3'd0, 8'd0);
        step();
        expect_now("reset_hold2", 3'b000, 1'b0, 3'd0, 8'd0);

        // Release reset: WAIT_LOCK one edge later; lock seen the cycle after.
        rst_n = 1'b1;
        step();
        expect_now("wait_lock", 3'b000, 1'b0, 3'd1, 8'd0);
        step();
        expect_now("boot_c", 3'b000, 1'b0, 3'd1, 8'd0);
        run_sequence("boot", 8'd0, 1);

        // One-cycle lock drop in RUN.
        locked = 1'b0;
        step();
        locked = 1'b1;
        expect_now("drop_r1", 3'b111, 1'b1, 3'd4, 8'd0);
        step();
        expect_now("drop_r2", 3'b111, 1'b1, 3'd4, 8'd0);
        step();
        exp_cnt = 1;
        expect_now("drop_r3", 3'b000, 1'b0, 3'd1, 8'(exp_cnt));
        run_sequence("replay", 8'(exp_cnt), 1);

        // Soft reset in RUN.
        soft_reset = 1'b1;
        step();
        soft_reset = 1'b0;
        seq_check("soft", 8'(exp_cnt), 1);
        run_sequence("soft", 8'(exp_cnt), 2);

        // Soft reset into SETTLE, then drop lock during SETTLE.
        soft_reset = 1'b1;
        step();
        soft_reset = 1'b0;
        seq_check("soft2", 8'(exp_cnt), 1);
        step();
        locked = 1'b0;
        step();
        expect_now("settle_drop1", 3'b000, 1'b0, 3'd2, 8'(exp_cnt));
        step();
        expect_now("settle_drop2", 3'b000, 1'b0, 3'd2, 8'(exp_cnt));
        for (int i = 0; i < 6; i++) begin
            step();
            expect_now("settle_drop_wait", 3'b000, 1'b0, 3'd1, 8'(exp_cnt));
        end
        locked = 1'b1;
        step();
        step();
        expect_now("relock_c", 3'b000, 1'b0, 3'd1, 8'(exp_cnt));
        run_sequence("relock", 8'(exp_cnt), 1);

        // Soft reset in the same cycle the synchronized lock falls: lock loss wins.
        locked = 1'b0;
        step();
        step();
        soft_reset = 1'b1;
        step();
        soft_reset = 1'b0;
        exp_cnt = 2;
        expect_now("both", 3'b000, 1'b0, 3'd1, 8'(exp_cnt));
        step();
        expect_now("both_hold", 3'b000, 1'b0, 3'd1, 8'(exp_cnt));

        // 300 lock losses, each taken from inside RELEASE; counter saturates.
        for (int i = 0; i < 300; i++) begin
            locked = 1'b1;
            repeat (11) step();
            locked = 1'b0;
            repeat (4) step();
            exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
            push_exp($sformatf("toggle%0d", i), 3'b000, 1'b0, 3'd1, 8'(exp_cnt));
            pop_check();
        end
        expect_now("saturated", 3'b000, 1'b0, 3'd1, 8'd255);

        // Asynchronous reset in the middle of RELEASE.
        locked = 1'b1;
        repeat (2) step();
        repeat (12) step();
        expect_now("mid_release", 3'b001, 1'b0, 3'd3, 8'd255);
        #2;
        rst_n = 1'b0;
        #1;
        expect_now("async_reset", 3'b000, 1'b0, 3'd0, 8'd0);
        step();
        expect_now("async_reset_hold", 3'b000, 1'b0, 3'd0, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
